// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetches 16-byte instruction groups and hands them out as four
// independently consumed lanes, with redirect flushing and in-flight response drop.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         fetch_req_valid,
  input  logic         fetch_req_ready,
  output logic [31:0]  fetch_req_pc,
  input  logic         fetch_resp_valid,
  input  logic [127:0] fetch_resp_data,
  output logic         ifu_instA_valid,
  input  logic         ifu_instA_allowIn,
  output logic [31:0]  ifu_instA_data,
  output logic [31:0]  ifu_instA_pc,
  output logic         ifu_instB_valid,
  input  logic         ifu_instB_allowIn,
  output logic [31:0]  ifu_instB_data,
  output logic [31:0]  ifu_instB_pc,
  output logic         ifu_instC_valid,
  input  logic         ifu_instC_allowIn,
  output logic [31:0]  ifu_instC_data,
  output logic [31:0]  ifu_instC_pc,
  output logic         ifu_instD_valid,
  input  logic         ifu_instD_allowIn,
  output logic [31:0]  ifu_instD_data,
  output logic [31:0]  ifu_instD_pc
);
  typedef enum logic [1:0] {REQ, WAIT, DROP, HOLD} stateT;
  stateT        state, stateNext;
  logic [31:0]  pc;
  logic [1:0]   startOff;
  logic [3:0]   pending, allowIn, remain;
  logic [127:0] buffer;
  logic         unusedBits;
  assign unusedBits = ^redirect_pc[1:0];
  assign allowIn = {ifu_instD_allowIn, ifu_instC_allowIn, ifu_instB_allowIn, ifu_instA_allowIn};
  assign remain = pending & ~allowIn;
  always_comb begin
    stateNext = state;
    if (redirect_valid)
      stateNext = (state == WAIT || state == DROP || (state == REQ && fetch_req_ready)) ? DROP : REQ;
    else
      case (state)
        REQ:     stateNext = fetch_req_ready ? WAIT : REQ;
        WAIT:    stateNext = fetch_resp_valid ? HOLD : WAIT;
        DROP:    stateNext = fetch_resp_valid ? REQ : DROP;
        default: stateNext = (remain == 4'b0) ? REQ : HOLD;
      endcase
  end
  // pending is only ever nonzero in HOLD, so it drives the lane valids directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      pc       <= {RESET_PC[31:4], 4'b0};
      startOff <= RESET_PC[3:2];
      pending  <= 4'b0;
      buffer   <= 128'b0;
    end else begin
      state <= stateNext;
      if (redirect_valid) begin
        pc       <= {redirect_pc[31:4], 4'b0};
        startOff <= redirect_pc[3:2];
        pending  <= 4'b0;
      end else if (state == WAIT && fetch_resp_valid) begin
        buffer   <= fetch_resp_data;
        pending  <= 4'hF << startOff;
        startOff <= 2'b0;
      end else if (state == HOLD) begin
        pending <= remain;
        if (remain == 4'b0) pc <= pc + 32'd16;
      end
    end
  end
  assign fetch_req_valid = (state == REQ);
  assign fetch_req_pc    = pc;
  assign {ifu_instD_valid, ifu_instC_valid, ifu_instB_valid, ifu_instA_valid} = pending;
  assign ifu_instA_data = buffer[31:0];
  assign ifu_instB_data = buffer[63:32];
  assign ifu_instC_data = buffer[95:64];
  assign ifu_instD_data = buffer[127:96];
  assign ifu_instA_pc = {pc[31:4], 4'h0};
  assign ifu_instB_pc = {pc[31:4], 4'h4};
  assign ifu_instC_pc = {pc[31:4], 4'h8};
  assign ifu_instD_pc = {pc[31:4], 4'hC};
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed bench for ifu_fetch_ctrl with hand-computed expectations.
module tb_ifu_fetch_ctrl;
  logic clk = 0, rst = 1;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic fetch_req_valid, fetch_req_ready = 0;
  logic [31:0] fetch_req_pc;
  logic fetch_resp_valid = 0;
  logic [127:0] fetch_resp_data = 0;
  logic aV, bV, cV, dV;
  logic aAl = 0, bAl = 0, cAl = 0, dAl = 0;
  logic [31:0] aD, bD, cD, dD, aP, bP, cP, dP;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_pc(fetch_req_pc),
    .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
    .ifu_instA_valid(aV), .ifu_instA_allowIn(aAl), .ifu_instA_data(aD), .ifu_instA_pc(aP),
    .ifu_instB_valid(bV), .ifu_instB_allowIn(bAl), .ifu_instB_data(bD), .ifu_instB_pc(bP),
    .ifu_instC_valid(cV), .ifu_instC_allowIn(cAl), .ifu_instC_data(cD), .ifu_instC_pc(cP),
    .ifu_instD_valid(dV), .ifu_instD_allowIn(dAl), .ifu_instD_data(dD), .ifu_instD_pc(dP)
  );

  wire [3:0] v = {dV, cV, bV, aV};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic allow(input logic [3:0] m);
    {dAl, cAl, bAl, aAl} = m;
  endtask

  function automatic logic [127:0] grp(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  initial begin
    step();
    step();
    chk("rst_valids", {28'b0, v}, 0);
    chk("rst_pc", fetch_req_pc, 32'h8000_0000);
    rst = 0;
    step();
    chk("first_req_valid", {31'b0, fetch_req_valid}, 1);
    chk("first_req_pc", fetch_req_pc, 32'h8000_0000);
    chk("first_valids", {28'b0, v}, 0);
    // basic group, all lanes consumed at once
    fetch_req_ready = 1;
    step();
    fetch_req_ready = 0;
    chk("wait_no_req", {31'b0, fetch_req_valid}, 0);
    fetch_resp_valid = 1;
    fetch_resp_data = grp(32'hA000_0000);
    step();
    fetch_resp_valid = 0;
    chk("g1_valids", {28'b0, v}, 4'hF);
    chk("g1_a_data", aD, 32'hA000_0000);
    chk("g1_d_data", dD, 32'hA000_0003);
    chk("g1_b_pc", bP, 32'h8000_0004);
    chk("g1_d_pc", dP, 32'h8000_000C);
    allow(4'hF);
    step();
    allow(4'h0);
    chk("g1_done_valids", {28'b0, v}, 0);
    chk("g2_req_valid", {31'b0, fetch_req_valid}, 1);
    chk("g2_req_pc", fetch_req_pc, 32'h8000_0010);
    // split consumption A,C then B,D
    fetch_req_ready = 1;
    step();
    fetch_req_ready = 0;
    fetch_resp_valid = 1;
    fetch_resp_data = grp(32'hB000_0000);
    step();
    fetch_resp_valid = 0;
    chk("g2_valids", {28'b0, v}, 4'hF);
    step();
    chk("g2_stall_valids", {28'b0, v}, 4'hF);
    chk("g2_stall_c_data", cD, 32'hB000_0002);
    allow(4'b0101);
    step();
    chk("g2_ac_gone", {28'b0, v}, 4'b1010);
    chk("g2_no_req_yet", {31'b0, fetch_req_valid}, 0);
    chk("g2_d_data", dD, 32'hB000_0003);
    allow(4'b1010);
    step();
    allow(4'h0);
    chk("g2_bd_gone", {28'b0, v}, 0);
    chk("g3_req_pc", fetch_req_pc, 32'h8000_0020);
    // redirect during HOLD to an unaligned target
    fetch_req_ready = 1;
    step();
    fetch_req_ready = 0;
    fetch_resp_valid = 1;
    fetch_resp_data = grp(32'hC000_0000);
    step();
    fetch_resp_valid = 0;
    chk("g3_valids", {28'b0, v}, 4'hF);
    redirect_valid = 1;
    redirect_pc = 32'h0000_100B;
    step();
    redirect_valid = 0;
    chk("rd_hold_valids", {28'b0, v}, 0);
    chk("rd_hold_req", {31'b0, fetch_req_valid}, 1);
    chk("rd_hold_pc", fetch_req_pc, 32'h0000_1000);
    fetch_req_ready = 1;
    step();
    fetch_req_ready = 0;
    fetch_resp_valid = 1;
    fetch_resp_data = grp(32'hD000_0000);
    step();
    fetch_resp_valid = 0;
    chk("rd_first_valids", {28'b0, v}, 4'b1100);
    chk("rd_c_pc", cP, 32'h0000_1008);
    chk("rd_d_pc", dP, 32'h0000_100C);
    chk("rd_c_data", cD, 32'hD000_0002);
    allow(4'b1100);
    step();
    allow(4'h0);
    chk("rd_next_pc", fetch_req_pc, 32'h0000_1010);
    fetch_req_ready = 1;
    step();
    fetch_req_ready = 0;
    fetch_resp_valid = 1;
    fetch_resp_data = grp(32'hE000_0000);
    step();
    fetch_resp_valid = 0;
    chk("rd_seq_valids", {28'b0, v}, 4'hF);
    chk("rd_seq_a_pc", aP, 32'h0000_1010);
    allow(4'hF);
    step();
    allow(4'h0);
    chk("rd_seq_next_pc", fetch_req_pc, 32'h0000_1020);
    // stray response in REQ is ignored
    fetch_resp_valid = 1;
    fetch_resp_data = grp(32'h1111_0000);
    step();
    fetch_resp_valid = 0;
    chk("stray_req_valid", {31'b0, fetch_req_valid}, 1);
    chk("stray_valids", {28'b0, v}, 0);
    // redirect during WAIT, late response dropped
    fetch_req_ready = 1;
    step();
    fetch_req_ready = 0;
    redirect_valid = 1;
    redirect_pc = 32'h0000_2000;
    step();
    redirect_valid = 0;
    chk("drop_no_req", {31'b0, fetch_req_valid}, 0);
    step();
    step();
    fetch_resp_valid = 1;
    fetch_resp_data = grp(32'h2222_0000);
    step();
    fetch_resp_valid = 0;
    chk("drop_valids", {28'b0, v}, 0);
    chk("drop_buf_kept", aD, 32'hE000_0000);
    chk("drop_req_valid", {31'b0, fetch_req_valid}, 1);
    chk("drop_req_pc", fetch_req_pc, 32'h0000_2000);
    // address wrap
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFF0;
    step();
    redirect_valid = 0;
    chk("wrap_req_pc", fetch_req_pc, 32'hFFFF_FFF0);
    fetch_req_ready = 1;
    step();
    fetch_req_ready = 0;
    fetch_resp_valid = 1;
    fetch_resp_data = grp(32'hF000_0000);
    step();
    fetch_resp_valid = 0;
    chk("wrap_valids", {28'b0, v}, 4'hF);
    chk("wrap_d_pc", dP, 32'hFFFF_FFFC);
    allow(4'hF);
    step();
    allow(4'h0);
    chk("wrap_next_pc", fetch_req_pc, 32'h0000_0000);
    // reset mid-HOLD with partial pending
    fetch_req_ready = 1;
    step();
    fetch_req_ready = 0;
    fetch_resp_valid = 1;
    fetch_resp_data = grp(32'h3333_0000);
    step();
    fetch_resp_valid = 0;
    allow(4'b0001);
    step();
    allow(4'h0);
    chk("partial_valids", {28'b0, v}, 4'b1110);
    rst = 1;
    #1;
    chk("rst_hold_valids", {28'b0, v}, 0);
    step();
    rst = 0;
    step();
    chk("rst_hold_after", {28'b0, v}, 0);
    chk("rst_hold_pc", fetch_req_pc, 32'h8000_0000);
    chk("rst_hold_req", {31'b0, fetch_req_valid}, 1);
    // reset while WAIT
    fetch_req_ready = 1;
    step();
    fetch_req_ready = 0;
    rst = 1;
    step();
    rst = 0;
    step();
    chk("rst_wait_valids", {28'b0, v}, 0);
    chk("rst_wait_req", {31'b0, fetch_req_valid}, 1);
    chk("rst_wait_pc", fetch_req_pc, 32'h8000_0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
